// File: rtl/oven_ctrl.sv
// oven_ctrl: front-panel sequencer for the oven cook timer.
// Conditions the user controls, loads/runs/clears the external timer and
// drives heater, lamp and buzzer. Define OVEN_CTRL_PAUSE_EN to make an
// opened door pause cooking instead of aborting it.
module oven_ctrl #(
    parameter int BEEP_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       cancel_btn,
    input  logic       door_open,
    input  logic [3:0] time_sel,
    input  logic       timer_done,
    output logic       timer_load,
    output logic [3:0] timer_set,
    output logic       timer_run,
    output logic       timer_clear,
    output logic       heater_on,
    output logic       lamp_on,
    output logic       buzzer,
    output logic [1:0] state
);

    localparam int CNT_W = $clog2(BEEP_CYCLES + 1);
    localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q;
    state_t next_state;

    logic start_meta, start_sync, start_prev;
    logic cancel_meta, cancel_sync, cancel_prev;
    logic door_meta, door_s;
    logic start_p, cancel_p;

    logic [CNT_W-1:0] beep_cnt;

    logic accept;
    logic clear_req;
    logic heater_d, lamp_d, run_d, buzzer_d;

    // Two-flop synchronizers plus the previous-value flops for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            start_meta  <= 1'b0;
            start_sync  <= 1'b0;
            start_prev  <= 1'b0;
            cancel_meta <= 1'b0;
            cancel_sync <= 1'b0;
            cancel_prev <= 1'b0;
            door_meta   <= 1'b0;
            door_s      <= 1'b0;
        end else begin
            start_meta  <= start_btn;
            start_sync  <= start_meta;
            start_prev  <= start_sync;
            cancel_meta <= cancel_btn;
            cancel_sync <= cancel_meta;
            cancel_prev <= cancel_sync;
            door_meta   <= door_open;
            door_s      <= door_meta;
        end
    end

    assign start_p  = start_sync & ~start_prev;
    assign cancel_p = cancel_sync & ~cancel_prev;

    // A start request is only accepted from IDLE with the door shut and a valid time
    assign accept = (state_q == IDLE) && start_p && !door_s && (time_sel != 4'd0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state logic; clear_req flags transitions that must zero the timer
    always_comb begin
        next_state = state_q;
        clear_req  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    next_state = COOK;
                end
            end
            COOK: begin
                if (cancel_p) begin
                    next_state = IDLE;
                    clear_req  = 1'b1;
                end else if (timer_done) begin
                    next_state = DONE;
                end else if (door_s) begin
`ifdef OVEN_CTRL_PAUSE_EN
                    next_state = PAUSE;
`else
                    next_state = IDLE;
                    clear_req  = 1'b1;
`endif
                end
            end
`ifdef OVEN_CTRL_PAUSE_EN
            PAUSE: begin
                if (cancel_p) begin
                    next_state = IDLE;
                    clear_req  = 1'b1;
                end else if (start_p && !door_s) begin
                    next_state = COOK;
                end
            end
`endif
            DONE: begin
                if (cancel_p || door_s) begin
                    next_state = IDLE;
                end else if (beep_cnt == BEEP_LAST) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs align with it
    always_comb begin
        heater_d = 1'b0;
        lamp_d   = 1'b0;
        run_d    = 1'b0;
        buzzer_d = 1'b0;
        case (next_state)
            IDLE: begin
                lamp_d = door_s;
            end
            COOK: begin
                heater_d = 1'b1;
                lamp_d   = 1'b1;
                run_d    = 1'b1;
            end
            PAUSE: begin
                lamp_d = 1'b1;
            end
            DONE: begin
                buzzer_d = 1'b1;
            end
            default: begin
                lamp_d = 1'b0;
            end
        endcase
    end

    // Output registers; load and clear are single-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_load  <= 1'b0;
            timer_set   <= 4'd0;
            timer_run   <= 1'b0;
            timer_clear <= 1'b0;
            heater_on   <= 1'b0;
            lamp_on     <= 1'b0;
            buzzer      <= 1'b0;
        end else begin
            timer_load  <= accept;
            timer_clear <= clear_req;
            timer_run   <= run_d;
            heater_on   <= heater_d;
            lamp_on     <= lamp_d;
            buzzer      <= buzzer_d;
            if (accept) begin
                timer_set <= time_sel;
            end
        end
    end

    // Beep counter: held at zero outside DONE, counts the buzzer cycles inside it
    always_ff @(posedge clk) begin
        if (rst) begin
            beep_cnt <= '0;
        end else if (state_q != DONE) begin
            beep_cnt <= '0;
        end else if (beep_cnt != BEEP_LAST) begin
            beep_cnt <= beep_cnt + 1'b1;
        end
    end

    assign state = state_q;

endmodule

// File: doc/oven_ctrl.md
# oven_ctrl

Top-level sequencer for the oven CPLD that owns the cook timer. It takes the user controls (start, cancel, door switch, 4-bit time selection) and loads, runs and clears the timer. It also drives the heater, lamp and buzzer. It sits between the front-panel inputs and the `timer` block, which counts down and returns a done pulse.

## Interface
- `BEEP_CYCLES`, default 50_000_000: buzzer on-time in `clk` cycles (1 s at 50 MHz); must be ≥1.
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: synchronous, active-high reset.
- `start_btn` in 1: start/resume request, asynchronous, pre-debounced.
- `cancel_btn` in 1: cancel request, asynchronous, pre-debounced.
- `door_open` in 1: door switch, asynchronous, 1 = open.
- `time_sel` in 4: cook time selection, 0 = invalid.
- `timer_done` in 1: single-cycle pulse from the timer, synchronous to `clk`.
- `timer_load` out 1: one-cycle pulse that loads `timer_set` into the timer.
- `timer_set` out 4: latched cook time.
- `timer_run` out 1: timer counts while high.
- `timer_clear` out 1: one-cycle pulse that zeroes the timer.
- `heater_on` out 1: heater drive.
- `lamp_on` out 1: cavity lamp.
- `buzzer` out 1: buzzer drive.
- `state` out 2: IDLE=0, COOK=1, PAUSE=2, DONE=3.

## Operation
- Input conditioning:
  - `start_btn`, `cancel_btn` and `door_open` each pass through a 2-flop synchronizer.
  - `start_btn` and `cancel_btn` then get a rising-edge detector, giving the internal pulses `start_p` and `cancel_p`.
  - `door_s` is the synchronized level of `door_open`.
- IDLE:
  - Outputs: heater off, `lamp_on` = `door_s`, `timer_run` = 0.
  - On `start_p` with `door_s`=0 and `time_sel`≠0: latch `time_sel` into `timer_set`, pulse `timer_load`, go to COOK.
  - `start_p` with the door open or `time_sel`=0 is ignored.
- COOK:
  - Outputs: `heater_on`=1, `lamp_on`=1, `timer_run`=1.
  - Exit priority, highest first:
    - `cancel_p`: pulse `timer_clear`, go to IDLE.
    - `timer_done`: go to DONE.
    - `door_s`=1: door handling as set by the Configuration section.
- PAUSE (exists only with the macro):
  - Outputs: heater off, `lamp_on`=1, `timer_run`=0; the timer value is held.
  - `cancel_p` wins: pulse `timer_clear`, go to IDLE.
  - Otherwise `start_p` with `door_s`=0 goes to COOK with no reload.
- DONE:
  - Outputs: heater off, `lamp_on`=0, `buzzer`=1, beep counter runs.
  - After exactly `BEEP_CYCLES` cycles, go to IDLE.
  - `cancel_p` or `door_s`=1 goes to IDLE immediately; the buzzer drops on the next cycle.
- `start_p` during COOK or DONE is ignored.
- `time_sel` changes outside the IDLE accept cycle have no effect.
- Beep counter: width is $clog2(`BEEP_CYCLES`+1). It is cleared on DONE entry and counts up to `BEEP_CYCLES`-1; no wrap-around is reachable.

## Timing
- Reset:
  - The state machine goes to IDLE.
  - Outputs go to 0: `timer_load`, `timer_run`, `timer_clear`, `heater_on`, `lamp_on`, `buzzer`, `timer_set`.
  - The synchronizer flops and the beep counter go to 0.
- Reset mid-cook stops the heater on the next edge, with no `timer_clear` pulse; the timer has its own reset.
- All outputs are registered.
- Button latency: an input stable high before edge N gives `start_p`/`cancel_p` high after edge N+1. The state and outputs change at edge N+2.
- Door latency: `door_s` follows `door_open` after 2 edges.
- `timer_done` latency: a pulse sampled at edge M makes `state`=DONE and `buzzer`=1 after edge M.
- COOK entry: `timer_load`=1 and `timer_run`=1 in the same first COOK cycle. The timer gives load priority over run.
- `timer_load` and `timer_clear` are high for exactly one cycle.
- A button held high generates one pulse only; it must return low before it is recognised again.

## Configuration
- `OVEN_CTRL_PAUSE_EN` defined:
  - Door opening in COOK goes to PAUSE.
  - Resume requires the door closed plus `start_p`.
  - `state`=2 is reachable.
- Macro undefined:
  - PAUSE logic is not compiled.
  - Door opening in COOK aborts: pulse `timer_clear`, go to IDLE.
  - `state` never equals 2.

## Test plan
1. Normal cook, `BEEP_CYCLES`=8:
   - Stimulus: `rst` then `time_sel`=13, `start_btn` pulse, `timer_done` pulse 20 cycles later.
   - Required response: `timer_load` pulse with `timer_set`=13 and COOK with heater on, then DONE with `buzzer` high for exactly 8 cycles, then IDLE.
2. Invalid start:
   - Stimulus: `time_sel`=0 with `start_btn`, then `door_open`=1, `time_sel`=5 with `start_btn`.
   - Required response: stays IDLE, `timer_load` never asserted, `lamp_on`=1 while the door is open.
3. Cancel during COOK, plus a simultaneous event:
   - Stimulus: `cancel_btn` in COOK; later `cancel_p` and `timer_done` in the same cycle.
   - Required response: `timer_clear` one-cycle pulse and IDLE in both cases; `buzzer` stays 0.
4. Door open during COOK, both builds:
   - With the macro: PAUSE with heater 0 and `timer_run` 0; close the door and press start to return to COOK with no `timer_load`.
   - Without the macro: IDLE with a `timer_clear` pulse.
5. Mid-operation events:
   - Stimulus: `rst` asserted in COOK; `door_open` asserted in DONE.
   - Required response: after reset all outputs are 0 on the next edge; the door aborts the beep within 3 cycles of the door input.
6. Held button:
   - Stimulus: `start_btn` held high 100 cycles in IDLE with valid `time_sel`.
   - Required response: exactly one `timer_load`; no second load after the timer completes.
